spi_ram_master: RTL
===================

SPI_RAM_MASTER -- requirements
Module: spi_ram_master

Interface
REQ-001 Parameter ADDR_SIZE, default 8, width of SPI address/data payload.
REQ-002 Parameter MISO_GAP, default 2, idle cycles between last rd-data dummy bit and first MISO bit.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  2  per-requester transaction request, bit i for requester i.
REQ-006 we  input  2  per-requester op select: 1 write, 0 read; sampled with req.
REQ-007 addr0, addr1  input  ADDR_SIZE each  per-requester RAM address.
REQ-008 wdata0, wdata1  input  ADDR_SIZE each  per-requester write data.
REQ-009 done  output  2  one-cycle completion pulse to the granted requester.
REQ-010 rdata  output  ADDR_SIZE  read data; valid on the done pulse of a read.
REQ-011 busy  output  1  high from grant until end of transaction.
REQ-012 SS_n  output  1  slave select to SPI slave, active-low.
REQ-013 MOSI  output  1  serial data to SPI slave.
REQ-014 MISO  input  1  serial data from SPI slave.

Function
REQ-015 Write transaction: wr-addr frame (cmd 000) then wr-data frame (cmd 001); read: rd-addr frame (cmd 110) then rd-data frame (cmd 111).
REQ-016 Frame timing, cycle 0 = first cycle SS_n low: cycle 0 MOSI=0 start; cycles 1-3 cmd MSB first; cycles 4..3+ADDR_SIZE payload MSB first.
REQ-017 Addr frames carry addr; wr-data frame carries wdata; rd-data frame carries ADDR_SIZE zero dummy bits.
REQ-018 rd-data frame: after payload, MISO_GAP cycles SS_n low, MOSI=0; then ADDR_SIZE cycles sampling MISO MSB first into rdata shift register.
REQ-019 After every frame SS_n high for exactly one cycle (END) before next frame or IDLE.
REQ-020 SS_n and MOSI registered; SS_n=1, MOSI=0 whenever not in a frame.
REQ-021 FSM states: IDLE, START, CMD, PAYLOAD, GAP, RDATA, END; one bit counter sized for max(3, ADDR_SIZE, MISO_GAP); one phase bit (frame 1/2).
REQ-022 Transitions: IDLE->START on any req; START->CMD; CMD->PAYLOAD after 3; PAYLOAD->GAP (rd-data) or END after ADDR_SIZE; GAP->RDATA after MISO_GAP; RDATA->END after ADDR_SIZE; END->START (phase 1) or IDLE (phase 2).
REQ-023 Arbitration only in IDLE; grant, we, addr, wdata latched at grant; later input changes ignored until done.
REQ-024 done[i] pulses the cycle of END->IDLE; rdata updated on same edge for reads, held otherwise.
REQ-025 Requester must hold req until done; req dropped mid-transaction does not abort it.
REQ-026 Back-to-back: req still high in IDLE after done starts new arbitration next cycle; write latency 2*(5+ADDR_SIZE) cycles grant-to-done.
REQ-027 MISO_GAP=0 legal: GAP state skipped.

Reset
REQ-028 rst high: state IDLE, SS_n=1, MOSI=0, done=0, busy=0, rdata=0, arbiter pointer=0.
REQ-029 rst mid-frame: next cycle SS_n=1, transaction discarded, no done pulse.

Configuration
REQ-030 Macro SPI_MASTER_RR_ARB_EN defined: round-robin, pointer moves past winner on grant; simultaneous requests alternate.
REQ-031 Macro undefined: fixed priority, requester 0 always wins ties.

Structure
REQ-032 Shared package: state enum, cmd constants (CMD_WR_ADDR=000, CMD_WR_DATA=001, CMD_RD_ADDR=110, CMD_RD_DATA=111).
REQ-033 Sub-module spi_ram_arb: 2-requester arbiter, holds pointer and macro-dependent logic.

Verification
REQ-034 Req0 write addr=0x5A data=0xC3 -> MOSI frames 0,000,01011010 then 0,001,11000011; done[0] after 26 cycles.
REQ-035 Write 0x3C to 0xFF then read 0xFF against SPI wrapper -> rdata=0x3C with done[0].
REQ-036 req=2'b11 held, macro defined -> grants 0,1,0,1; undefined -> requester 0 only.
REQ-037 rst asserted during PAYLOAD -> SS_n=1 next cycle, no done, next req completes correctly.
REQ-038 addr0 changed mid-transaction -> frame uses latched address.
REQ-039 MISO_GAP=0 and 3 builds -> read of stored 0xA5 returns 0xA5.

Source files
------------

// File: rtl/spi_ram_master_pkg.sv
// ============================================================================
// Module   : spi_ram_master_pkg
// Brief    : Shared FSM state encoding, SPI command codes and helpers for the
//            SPI RAM master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_ram_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_CMD     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_GAP     = 3'd4,
        ST_RDATA   = 3'd5,
        ST_END     = 3'd6
    } state_t;

    localparam logic [2:0] CMD_WR_ADDR = 3'b000;
    localparam logic [2:0] CMD_WR_DATA = 3'b001;
    localparam logic [2:0] CMD_RD_ADDR = 3'b110;
    localparam logic [2:0] CMD_RD_DATA = 3'b111;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_ram_master_arb.sv
// ============================================================================
// Module   : spi_ram_arb
// Brief    : Two-requester arbiter. Round-robin when SPI_MASTER_RR_ARB_EN is
//            defined, fixed priority (requester 0 first) otherwise.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_ram_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       win,
    output logic       gnt
);

    logic r_gnt;

`ifdef SPI_MASTER_RR_ARB_EN
    // r_ptr names the requester that wins the next tie
    logic r_ptr;

    always_comb begin
        win = (req[0] & req[1]) ? r_ptr : req[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (grant_en) begin
            r_ptr <= ~win;
        end
    end
`else
    always_comb begin
        win = ~req[0] & req[1];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt <= 1'b0;
        end else if (grant_en) begin
            r_gnt <= win;
        end
    end

    assign gnt = r_gnt;

endmodule

`default_nettype wire

// File: rtl/spi_ram_master.sv
// ============================================================================
// Module   : spi_ram_master
// Brief    : Two-requester SPI RAM master; each transaction is an address
//            frame followed by a data frame. Arbitration mode selected by
//            SPI_MASTER_RR_ARB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_ram_master
    import spi_ram_master_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int MISO_GAP  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    input  logic [1:0]           we,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [ADDR_SIZE-1:0] wdata0,
    input  logic [ADDR_SIZE-1:0] wdata1,
    output logic [1:0]           done,
    output logic [ADDR_SIZE-1:0] rdata,
    output logic                 busy,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int c_CNT_W = $clog2(max3(3, ADDR_SIZE, MISO_GAP)) + 1;
    localparam int c_FRM_W = 3 + ADDR_SIZE;
    localparam logic [c_CNT_W-1:0] c_CMD_LAST = c_CNT_W'(2);
    localparam logic [c_CNT_W-1:0] c_PAY_LAST = c_CNT_W'(ADDR_SIZE - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'((MISO_GAP > 0) ? MISO_GAP - 1 : 0);

    state_t                 r_state, w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt, w_cnt_nxt, w_shamt;
    logic                   r_phase, r_we, r_ss_n, r_mosi, r_busy;
    logic [ADDR_SIZE-1:0]   r_addr, r_wdata, r_shift, r_rdata, w_payload;
    logic [1:0]             r_done;
    logic [2:0]             w_cmd;
    logic [c_FRM_W-1:0]     w_frame, w_frame_sh;
    logic                   w_grant, w_win, w_gnt, w_ss_n_nxt, w_mosi_nxt;

    spi_ram_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant_en (w_grant),
        .win      (w_win),
        .gnt      (w_gnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (|req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (r_cnt == c_CMD_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (r_cnt == c_PAY_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_phase && !r_we) begin
                        w_state_nxt = (MISO_GAP == 0) ? ST_RDATA : ST_GAP;
                    end else begin
                        w_state_nxt = ST_END;
                    end
                end
            end
            ST_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (r_cnt == c_PAY_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_END;
                end
            end
            ST_END: begin
                w_cnt_nxt   = '0;
                w_state_nxt = r_phase ? ST_IDLE : ST_START;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pins are registered, so they are derived from the state/count being entered
    always_comb begin
        w_cmd      = r_we ? (r_phase ? CMD_WR_DATA : CMD_WR_ADDR)
                          : (r_phase ? CMD_RD_DATA : CMD_RD_ADDR);
        w_payload  = r_phase ? (r_we ? r_wdata : '0) : r_addr;
        w_frame    = {w_cmd, w_payload};
        w_shamt    = (w_state_nxt == ST_PAYLOAD) ? w_cnt_nxt + c_CNT_W'(3) : w_cnt_nxt;
        w_frame_sh = w_frame << w_shamt;
        w_ss_n_nxt = !(w_state_nxt inside {ST_START, ST_CMD, ST_PAYLOAD, ST_GAP, ST_RDATA});
        w_mosi_nxt = ((w_state_nxt == ST_CMD) || (w_state_nxt == ST_PAYLOAD))
                     && w_frame_sh[c_FRM_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_shift <= '0;
            r_rdata <= '0;
            r_done  <= 2'b00;
            r_busy  <= 1'b0;
            r_ss_n  <= 1'b1;
            r_mosi  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ss_n  <= w_ss_n_nxt;
            r_mosi  <= w_mosi_nxt;
            r_done  <= 2'b00;
            if (w_grant) begin
                r_we    <= we[w_win];
                r_addr  <= w_win ? addr1 : addr0;
                r_wdata <= w_win ? wdata1 : wdata0;
                r_phase <= 1'b0;
                r_busy  <= 1'b1;
            end
            if (r_state == ST_RDATA) begin
                r_shift <= {r_shift[ADDR_SIZE-2:0], MISO};
            end
            if (r_state == ST_END) begin
                r_phase <= 1'b1;
                if (r_phase) begin
                    r_busy <= 1'b0;
                    r_done <= w_gnt ? 2'b10 : 2'b01;
                    if (!r_we) begin
                        r_rdata <= r_shift;
                    end
                end
            end
        end
    end

    assign done  = r_done;
    assign rdata = r_rdata;
    assign busy  = r_busy;
    assign SS_n  = r_ss_n;
    assign MOSI  = r_mosi;

endmodule

`default_nettype wire
